// File: rtl/alu_mem_exec_unit_pkg.sv
// Shared encodings for the execute/memory block: ALUop classes, funct codes,
// 4-bit ALU control codes and memory operation encodings.
package alu_mem_exec_unit_pkg;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_SLT   = 3'b101;
  localparam logic [2:0] ALUOP_XOR   = 3'b110;
  localparam logic [2:0] ALUOP_LUI   = 3'b111;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [3:0] CTRL_AND  = 4'b0000;
  localparam logic [3:0] CTRL_OR   = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_XOR  = 4'b0011;
  localparam logic [3:0] CTRL_SLL  = 4'b0100;
  localparam logic [3:0] CTRL_SRL  = 4'b0101;
  localparam logic [3:0] CTRL_SUB  = 4'b0110;
  localparam logic [3:0] CTRL_SLT  = 4'b0111;
  localparam logic [3:0] CTRL_SRA  = 4'b1000;
  localparam logic [3:0] CTRL_SLTU = 4'b1001;
  localparam logic [3:0] CTRL_LUI  = 4'b1010;
  localparam logic [3:0] CTRL_NOR  = 4'b1100;
  localparam logic [3:0] CTRL_INV  = 4'b1111;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic WB_WORD = 1'b0;
  localparam logic WB_BYTE = 1'b1;

endpackage

// File: rtl/alu_mem_exec_unit_alu_ctrl_decode.sv
// ALUop + funct to 4-bit ALU control code. Shift functs decode only when
// ALU_SHIFT_EN is defined; otherwise they fall through to INVALID.
module alu_ctrl_decode
  import alu_mem_exec_unit_pkg::*;
(
  input  logic [2:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [3:0] ctrl_o
);

  logic [3:0] fn_ctrl;

  always_comb begin
    fn_ctrl = CTRL_INV;
    case (funct_i)
      FN_ADD, FN_ADDU, FN_JR: fn_ctrl = CTRL_ADD;
      FN_SUB, FN_SUBU:        fn_ctrl = CTRL_SUB;
      FN_AND:                 fn_ctrl = CTRL_AND;
      FN_OR:                  fn_ctrl = CTRL_OR;
      FN_XOR:                 fn_ctrl = CTRL_XOR;
      FN_NOR:                 fn_ctrl = CTRL_NOR;
      FN_SLT:                 fn_ctrl = CTRL_SLT;
      FN_SLTU:                fn_ctrl = CTRL_SLTU;
`ifdef ALU_SHIFT_EN
      FN_SLL:                 fn_ctrl = CTRL_SLL;
      FN_SRL:                 fn_ctrl = CTRL_SRL;
      FN_SRA:                 fn_ctrl = CTRL_SRA;
`endif
      default:                fn_ctrl = CTRL_INV;
    endcase
  end

  always_comb begin
    ctrl_o = CTRL_INV;
    case (aluop_i)
      ALUOP_ADD:   ctrl_o = CTRL_ADD;
      ALUOP_SUB:   ctrl_o = CTRL_SUB;
      ALUOP_FUNCT: ctrl_o = fn_ctrl;
      ALUOP_AND:   ctrl_o = CTRL_AND;
      ALUOP_OR:    ctrl_o = CTRL_OR;
      ALUOP_SLT:   ctrl_o = CTRL_SLT;
      ALUOP_XOR:   ctrl_o = CTRL_XOR;
      ALUOP_LUI:   ctrl_o = CTRL_LUI;
      default:     ctrl_o = CTRL_INV;
    endcase
  end

endmodule

// File: rtl/alu_mem_exec_unit.sv
// Execute/memory datapath: combinational ALU + little-endian byte-addressed
// data memory with clocked writes. Shifter is built only with ALU_SHIFT_EN.
module alu_mem_exec_unit
  import alu_mem_exec_unit_pkg::*;
#(
  parameter int DMEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  ALUop,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [31:0] ALUOut,
  output logic        ZF,
  output logic [3:0]  ALUcontrol_signal,
  input  logic [1:0]  Mem_Write_Read,
  input  logic        word_byte,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] Read_data
);

  localparam int AW = $clog2(DMEM_BYTES);

  logic [3:0] ctrl;

  alu_ctrl_decode u_dec (
    .aluop_i (ALUop),
    .funct_i (funct),
    .ctrl_o  (ctrl)
  );

  assign ALUcontrol_signal = ctrl;

  always_comb begin
    ALUOut = '0;
    case (ctrl)
      CTRL_AND:  ALUOut = op1 & op2;
      CTRL_OR:   ALUOut = op1 | op2;
      CTRL_ADD:  ALUOut = op1 + op2;
      CTRL_XOR:  ALUOut = op1 ^ op2;
      CTRL_SUB:  ALUOut = op1 - op2;
      CTRL_SLT:  ALUOut = {31'b0, $signed(op1) < $signed(op2)};
      CTRL_SLTU: ALUOut = {31'b0, op1 < op2};
      CTRL_LUI:  ALUOut = {op2[15:0], 16'b0};
      CTRL_NOR:  ALUOut = ~(op1 | op2);
`ifdef ALU_SHIFT_EN
      CTRL_SLL:  ALUOut = op2 << shamt;
      CTRL_SRL:  ALUOut = op2 >> shamt;
      CTRL_SRA:  ALUOut = $signed(op2) >>> shamt;
`endif
      default:   ALUOut = '0;
    endcase
  end

  assign ZF = (ALUOut == 32'd0);

`ifndef ALU_SHIFT_EN
  logic unused_shamt;
  assign unused_shamt = ^shamt;
`endif

  // Address wraps modulo DMEM_BYTES; word accesses use the aligned base.
  logic [AW-1:0] idx, widx;
  logic [7:0]    mem_q [DMEM_BYTES];
  logic          unused_addr;

  assign idx         = mem_addr[AW-1:0];
  assign widx        = idx & ~AW'(3);
  assign unused_addr = ^mem_addr[31:AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DMEM_BYTES; i++) mem_q[i] <= '0;
    end else if (Mem_Write_Read == MEM_WRITE) begin
      if (word_byte == WB_BYTE) begin
        mem_q[idx] <= mem_wdata[7:0];
      end else begin
        mem_q[widx]          <= mem_wdata[7:0];
        mem_q[widx + AW'(1)] <= mem_wdata[15:8];
        mem_q[widx + AW'(2)] <= mem_wdata[23:16];
        mem_q[widx + AW'(3)] <= mem_wdata[31:24];
      end
    end
  end

  always_comb begin
    Read_data = '0;
    if (Mem_Write_Read == MEM_READ) begin
      if (word_byte == WB_BYTE)
        Read_data = {{24{mem_q[idx][7]}}, mem_q[idx]};
      else
        Read_data = {mem_q[widx + AW'(3)], mem_q[widx + AW'(2)],
                     mem_q[widx + AW'(1)], mem_q[widx]};
    end
  end

endmodule

// File: tb/tb_alu_mem_exec_unit.sv
// Scoreboarded bench for alu_mem_exec_unit: expected values are queued when
// stimulus is driven and popped when outputs are sampled on the falling edge.
module tb_alu_mem_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  ALUop;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] op1, op2, ALUOut, mem_addr, mem_wdata, Read_data;
  logic        ZF, word_byte;
  logic [3:0]  ALUcontrol_signal;
  logic [1:0]  Mem_Write_Read;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    bit          is_alu;
    logic [31:0] data;
    logic [3:0]  ctrl;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  alu_mem_exec_unit #(.DMEM_BYTES(256)) dut (
    .clk(clk), .rst_n(rst_n), .ALUop(ALUop), .funct(funct), .shamt(shamt),
    .op1(op1), .op2(op2), .ALUOut(ALUOut), .ZF(ZF),
    .ALUcontrol_signal(ALUcontrol_signal), .Mem_Write_Read(Mem_Write_Read),
    .word_byte(word_byte), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .Read_data(Read_data)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Sample at the falling edge and retire one scoreboard entry.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      if (e.is_alu) begin
        chk({e.tag, ".out"},  ALUOut, e.data);
        chk({e.tag, ".zf"},   {31'b0, ZF}, {31'b0, e.data == 32'd0});
        chk({e.tag, ".ctrl"}, {28'b0, ALUcontrol_signal}, {28'b0, e.ctrl});
      end else begin
        chk(e.tag, Read_data, e.data);
      end
    end
    step();
  endtask

  task automatic alu(input string tag, input logic [2:0] aop, input logic [5:0] fn,
                     input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_out, input logic [3:0] exp_ctrl);
    ALUop = aop; funct = fn; shamt = sh; op1 = a; op2 = b;
    sb_q.push_back('{tag, 1'b1, exp_out, exp_ctrl});
    sample();
  endtask

  task automatic mem_wr(input logic [31:0] addr, input logic [31:0] data, input logic wb);
    Mem_Write_Read = 2'b10; mem_addr = addr; mem_wdata = data; word_byte = wb;
    step();
    Mem_Write_Read = 2'b00;
  endtask

  task automatic mem_rd(input string tag, input logic [31:0] addr, input logic wb,
                        input logic [31:0] exp);
    Mem_Write_Read = 2'b01; mem_addr = addr; word_byte = wb;
    sb_q.push_back('{tag, 1'b0, exp, 4'd0});
    sample();
    Mem_Write_Read = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rb;
    rst_n = 1'b0; ALUop = '0; funct = '0; shamt = '0; op1 = '0; op2 = '0;
    Mem_Write_Read = 2'b00; word_byte = 1'b0; mem_addr = '0; mem_wdata = '0;
    #2;
    mem_rd("rst_rd0", 32'd0, 1'b0, 32'd0);
    mem_rd("rst_rd252", 32'd252, 1'b0, 32'd0);
    rst_n = 1'b1;
    step();

    alu("add",    3'b000, 6'h00, 5'd0, 32'd7, 32'd8, 32'd15, 4'b0010);
    alu("sub",    3'b001, 6'h00, 5'd0, 32'd3, 32'd5, 32'hFFFFFFFE, 4'b0110);
    alu("and",    3'b011, 6'h00, 5'd0, 32'hF0F0, 32'hFF00, 32'hF000, 4'b0000);
    alu("or",     3'b100, 6'h00, 5'd0, 32'hF0F0, 32'h0F00, 32'hFFF0, 4'b0001);
    alu("slt",    3'b101, 6'h00, 5'd0, 32'hFFFFFFFF, 32'd1, 32'd1, 4'b0111);
    alu("xor",    3'b110, 6'h00, 5'd0, 32'hFF00FF00, 32'hFFFF0000, 32'h00FFFF00, 4'b0011);
    alu("lui",    3'b111, 6'h00, 5'd0, 32'hDEAD, 32'h12345678, 32'h56780000, 4'b1010);
    alu("fsub_z", 3'b010, 6'b100010, 5'd0, 32'd5, 32'd5, 32'd0, 4'b0110);
    alu("fsubu",  3'b010, 6'b100011, 5'd0, 32'd0, 32'd1, 32'hFFFFFFFF, 4'b0110);
    alu("fslt",   3'b010, 6'b101010, 5'd0, 32'hFFFFFFFF, 32'd1, 32'd1, 4'b0111);
    alu("fsltu",  3'b010, 6'b101011, 5'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 4'b1001);
    alu("fnor",   3'b010, 6'b100111, 5'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 4'b1100);
    alu("faddov", 3'b010, 6'b100001, 5'd0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 4'b0010);
    alu("fjr",    3'b010, 6'b001000, 5'd0, 32'h100, 32'd8, 32'h108, 4'b0010);
    alu("fand",   3'b010, 6'b100100, 5'd0, 32'hC3, 32'h0F, 32'h03, 4'b0000);
    alu("for",    3'b010, 6'b100101, 5'd0, 32'hC0, 32'h0F, 32'hCF, 4'b0001);
    alu("fxor",   3'b010, 6'b100110, 5'd0, 32'hAA, 32'hFF, 32'h55, 4'b0011);
    alu("finv",   3'b010, 6'b111111, 5'd0, 32'd9, 32'd9, 32'd0, 4'b1111);
`ifdef ALU_SHIFT_EN
    alu("sra",    3'b010, 6'b000011, 5'd4,  32'd0, 32'h80000000, 32'hF8000000, 4'b1000);
    alu("sll",    3'b010, 6'b000000, 5'd8,  32'd0, 32'd1, 32'h100, 4'b0100);
    alu("srl",    3'b010, 6'b000010, 5'd31, 32'd0, 32'h80000000, 32'd1, 4'b0101);
`else
    alu("sra",    3'b010, 6'b000011, 5'd4,  32'd0, 32'h80000000, 32'd0, 4'b1111);
    alu("sll",    3'b010, 6'b000000, 5'd8,  32'd0, 32'd1, 32'd0, 4'b1111);
    alu("srl",    3'b010, 6'b000010, 5'd31, 32'd0, 32'h80000000, 32'd0, 4'b1111);
`endif
    for (int i = 0; i < 4; i++) begin
      ra = $urandom; rb = $urandom;
      alu("radd", 3'b000, 6'h00, 5'd0, ra, rb, ra + rb, 4'b0010);
      alu("rsub", 3'b010, 6'b100010, 5'd0, ra, rb, ra - rb, 4'b0110);
    end

    mem_wr(32'd8, 32'h11223380, 1'b0);
    mem_rd("rdb8",  32'd8,  1'b1, 32'hFFFFFF80);
    mem_rd("rdb11", 32'd11, 1'b1, 32'h00000011);
    mem_rd("rdw9",  32'd9,  1'b0, 32'h11223380);
    mem_wr(32'd4, 32'h0, 1'b0);
    mem_wr(32'd5, 32'h123456AB, 1'b1);
    mem_rd("rdw6",  32'd6,  1'b0, 32'h0000AB00);
    mem_wr(32'd259, 32'h7F, 1'b1);
    mem_rd("wrap3", 32'd3,  1'b1, 32'h0000007F);
    Mem_Write_Read = 2'b11; mem_addr = 32'd8; mem_wdata = 32'hFFFFFFFF; word_byte = 1'b0;
    sb_q.push_back('{"rd_idle11", 1'b0, 32'd0, 4'd0});
    sample();
    Mem_Write_Read = 2'b00;
    mem_rd("no_wr11", 32'd8, 1'b0, 32'h11223380);

    mem_wr(32'd0, 32'hDEADBEEF, 1'b0);
    mem_rd("pre_rst", 32'd0, 1'b0, 32'hDEADBEEF);
    rst_n = 1'b0; #2; rst_n = 1'b1;
    mem_rd("post_rst", 32'd0, 1'b0, 32'd0);
    mem_rd("rst_clr8", 32'd8, 1'b0, 32'd0);
    rst_n = 1'b0;
    mem_wr(32'd0, 32'h12345678, 1'b0);
    rst_n = 1'b1;
    mem_rd("wr_in_rst", 32'd0, 1'b0, 32'd0);

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
